dest_forward_unit: RTL and testbench
====================================

DEST_FORWARD_UNIT -- requirements
Module: dest_forward_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports named clk and rst.
REQ-002 The block SHALL have the port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have the port id_valid, input, 1 bit: the ID-stage slot holds a real instruction.
REQ-005 The block SHALL have the ports id_rs and id_rt, input, [5:1] each: ID-stage source register numbers.
REQ-006 The block SHALL have the port id_dest, input, [5:1]: ID-stage destination register, already selected from rt or rd.
REQ-007 The block SHALL have the port id_regwrite, input, 1 bit: the ID instruction writes id_dest.
REQ-008 The block SHALL have the port id_memread, input, 1 bit: the ID instruction is a load.
REQ-009 The block SHALL have the port flush, input, 1 bit: squash the ID instruction instead of advancing it.
REQ-010 The block SHALL have the port stall, output, 1 bit: load-use hazard, so hold PC and ID.
REQ-011 The block SHALL have the ports fwd_a and fwd_b, output, [2:1] each: EX operand source. 00 = regfile, 01 = MEM-stage result, 10 = WB-stage result, 11 is unused.
REQ-012 The block SHALL have the ports ex_dest, mem_dest and wb_dest, output, [5:1] each: tracked destination per stage.
REQ-013 The block SHALL have the port wb_regwrite, output, 1 bit: the WB stage commits to wb_dest.

Function
REQ-014 Internal stage registers EX, MEM and WB SHALL each hold the fields valid, dest[5:1], regwrite and memread.
REQ-015 Each rising clk SHALL move MEM into WB and EX into MEM, unconditionally.
REQ-016 The EX load on a rising clk SHALL be ID fields when !stall && !flush, and otherwise a bubble (valid = 0, regwrite = 0, memread = 0, dest = 0).
REQ-017 A producer SHALL mean a stage with valid && regwrite && dest != 0; register 0 SHALL never match.
REQ-018 stall SHALL be combinational and equal id_valid && EX.valid && EX.memread && EX.regwrite && EX.dest != 0 && (EX.dest == id_rs || EX.dest == id_rt).
REQ-019 fwd_a SHALL be registered and update only on edges where ID advances into EX (!stall && !flush && id_valid).
REQ-020 On such an edge, fwd_a SHALL become 01 if the current EX is a non-load producer with dest == id_rs.
REQ-021 Otherwise on such an edge, fwd_a SHALL become 10 if the current MEM is a producer with dest == id_rs.
REQ-022 Otherwise on such an edge, fwd_a SHALL become 00.
REQ-023 The EX-over-MEM priority SHALL select the youngest producer.
REQ-024 fwd_b SHALL follow the same rules as fwd_a, using id_rt in place of id_rs.
REQ-025 On bubble edges (stall, flush, or !id_valid), fwd_a and fwd_b SHALL load 00.
REQ-026 After a one-cycle load-use stall, the load SHALL be in MEM while ID advances, so the forward code SHALL resolve to 10 on the following edge.
REQ-027 When stall and flush are both asserted, flush SHALL win: a bubble is inserted, and stall is still reported combinationally.
REQ-028 ex_dest, mem_dest and wb_dest SHALL directly reflect the EX.dest, MEM.dest and WB.dest registers.
REQ-029 wb_regwrite SHALL equal WB.valid && WB.regwrite.
REQ-030 The block SHALL hold no other state and SHALL be implementable in 120-400 lines.

Reset
REQ-031 While rst = 1, all stage fields SHALL be 0, fwd_a and fwd_b SHALL be 00, all dest outputs SHALL be 0, and wb_regwrite SHALL be 0.
REQ-032 While rst = 1, stall SHALL be 0 because EX.valid = 0.
REQ-033 Reset asserted mid-pipeline SHALL discard all in-flight entries immediately and without waiting for clk.
REQ-034 The first edge after rst is released SHALL behave as a normal advance.

Verification
REQ-035 Back-to-back ALU: add r3 (dest 3, regwrite), then sub with rs = 3 -> fwd_a = 01 in the sub's EX cycle; fwd_b = 00.
REQ-036 Distance two: writer dest 5, one unrelated instruction, then reader rt = 5 -> fwd_b = 10; with intervening writer also dest 5 -> fwd_b = 01.
REQ-037 Load-use: lw dest 8 in EX, ID rs = 8 -> stall = 1 for exactly one cycle, EX gets a bubble, then fwd_a = 10.
REQ-038 Register zero: writer dest 0 with regwrite, reader rs = 0 -> fwd_a = 00 and stall = 0.
REQ-039 Flush: flush = 1 with a valid ID writer dest 9 -> ex_dest = 0, and wb_regwrite stays 0 three cycles later.
REQ-040 Async reset: assert rst between edges with three valid writers in flight -> all outputs 0 before the next clk edge, and wb_regwrite = 0 after release.

Source files
------------

// File: rtl/dest_forward_unit.sv
// dest_forward_unit: tracks the destination register of the instructions in
// EX, MEM and WB, detects load-use hazards against the ID-stage sources and
// chooses the forwarding source for both EX operands one edge ahead.
module dest_forward_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [5:1] id_rs,
  input  logic [5:1] id_rt,
  input  logic [5:1] id_dest,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       flush,
  output logic       stall,
  output logic [2:1] fwd_a,
  output logic [2:1] fwd_b,
  output logic [5:1] ex_dest,
  output logic [5:1] mem_dest,
  output logic [5:1] wb_dest,
  output logic       wb_regwrite
);

  typedef struct packed {
    logic       valid;
    logic [5:1] dest;
    logic       regwrite;
    logic       memread;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, dest: 5'd0, regwrite: 1'b0, memread: 1'b0};

  localparam logic [2:1] FWD_RF  = 2'b00;
  localparam logic [2:1] FWD_MEM = 2'b01;
  localparam logic [2:1] FWD_WB  = 2'b10;

  stage_t     ex_q, mem_q, wb_q;
  stage_t     ex_d;
  logic [2:1] fwd_a_q, fwd_a_d;
  logic [2:1] fwd_b_q, fwd_b_d;
  logic       stall_s;
  logic       advance_s;

  // A stage produces a value only if it really writes a non-zero register;
  // register 0 is hard-wired and must never be forwarded from.
  function automatic logic is_producer(input stage_t st);
    return st.valid && st.regwrite && (st.dest != 5'd0);
  endfunction

  // Forward code for one source register. EX is checked first because it
  // holds the youngest write; a load in EX has no data yet, so it is skipped
  // (that case is covered by the stall instead).
  function automatic logic [2:1] fwd_sel(input stage_t ex, input stage_t mem,
                                         input logic [5:1] src);
    logic [2:1] code;
    if (is_producer(ex) && !ex.memread && (ex.dest == src)) begin
      code = FWD_MEM;
    end else if (is_producer(mem) && (mem.dest == src)) begin
      code = FWD_WB;
    end else begin
      code = FWD_RF;
    end
    return code;
  endfunction

  // Load-use hazard: the load in EX writes a register that ID wants to read.
  always_comb begin
    stall_s = id_valid && ex_q.valid && ex_q.memread && ex_q.regwrite &&
              (ex_q.dest != 5'd0) &&
              ((ex_q.dest == id_rs) || (ex_q.dest == id_rt));
  end

  // EX next state and forward codes; flush wins over stall, both make a bubble.
  always_comb begin
    ex_d      = BUBBLE;
    fwd_a_d   = FWD_RF;
    fwd_b_d   = FWD_RF;
    advance_s = !stall_s && !flush && id_valid;
    if (!stall_s && !flush) begin
      ex_d = '{valid: id_valid, dest: id_dest, regwrite: id_regwrite, memread: id_memread};
    end else begin
      ex_d = BUBBLE;
    end
    if (advance_s) begin
      fwd_a_d = fwd_sel(ex_q, mem_q, id_rs);
      fwd_b_d = fwd_sel(ex_q, mem_q, id_rt);
    end else begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end
  end

  // Pipeline shift and forward-code registers; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign stall       = stall_s;
  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign ex_dest     = ex_q.dest;
  assign mem_dest    = mem_q.dest;
  assign wb_dest     = wb_q.dest;
  assign wb_regwrite = wb_q.valid && wb_q.regwrite;

endmodule

// File: tb/tb_dest_forward_unit.sv
// Directed, table-driven bench for dest_forward_unit with a few hand-written
// reset sequences.
module tb_dest_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [5:1] id_rs, id_rt, id_dest;
  logic       id_regwrite, id_memread, flush;
  logic       stall;
  logic [2:1] fwd_a, fwd_b;
  logic [5:1] ex_dest, mem_dest, wb_dest;
  logic       wb_regwrite;

  int total = 0;
  int bad   = 0;

  dest_forward_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .wb_regwrite(wb_regwrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, dest;
    logic       rw, mr, fl;
    logic       st;
    logic [1:0] fa, fb;
    logic [4:0] exd, memd, wbd;
    logic       wbrw;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] dest, input logic rw, input logic mr,
                              input logic fl, input logic st, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [4:0] exd,
                              input logic [4:0] memd, input logic [4:0] wbd,
                              input logic wbrw);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.dest = dest; r.rw = rw; r.mr = mr; r.fl = fl;
    r.st = st; r.fa = fa; r.fb = fb; r.exd = exd; r.memd = memd; r.wbd = wbd;
    r.wbrw = wbrw;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dest, input logic rw, input logic mr,
                       input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_dest = dest;
    id_regwrite = rw; id_memread = mr; flush = fl;
  endtask

  task automatic chk_regs(input int idx, input logic [1:0] fa, input logic [1:0] fb,
                          input logic [4:0] exd, input logic [4:0] memd,
                          input logic [4:0] wbd, input logic wbrw);
    chk("fwd_a", idx, 32'(fwd_a), 32'(fa));
    chk("fwd_b", idx, 32'(fwd_b), 32'(fb));
    chk("ex_dest", idx, 32'(ex_dest), 32'(exd));
    chk("mem_dest", idx, 32'(mem_dest), 32'(memd));
    chk("wb_dest", idx, 32'(wb_dest), 32'(wbd));
    chk("wb_regwrite", idx, 32'(wb_regwrite), 32'(wbrw));
  endtask

  initial begin
    //               v     rs     rt     dest   rw    mr    fl    st    fa     fb     exd    memd   wbd    wbrw
    vecs[0]  = mk(1'b1, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd3,  5'd0,  5'd0,  1'b0);
    vecs[1]  = mk(1'b1, 5'd3,  5'd4,  5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 5'd6,  5'd3,  5'd0,  1'b0);
    vecs[2]  = mk(1'b1, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd5,  5'd6,  5'd3,  1'b1);
    vecs[3]  = mk(1'b1, 5'd1,  5'd2,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd7,  5'd5,  5'd6,  1'b1);
    vecs[4]  = mk(1'b1, 5'd1,  5'd5,  5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 5'd10, 5'd7,  5'd5,  1'b1);
    vecs[5]  = mk(1'b1, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd5,  5'd10, 5'd7,  1'b1);
    vecs[6]  = mk(1'b1, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd5,  5'd5,  5'd10, 1'b0);
    vecs[7]  = mk(1'b1, 5'd2,  5'd5,  5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 5'd11, 5'd5,  5'd5,  1'b1);
    vecs[8]  = mk(1'b1, 5'd1,  5'd2,  5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd8,  5'd11, 5'd5,  1'b1);
    vecs[9]  = mk(1'b1, 5'd8,  5'd3,  5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 5'd0,  5'd8,  5'd11, 1'b1);
    vecs[10] = mk(1'b1, 5'd8,  5'd3,  5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 5'd12, 5'd0,  5'd8,  1'b1);
    vecs[11] = mk(1'b1, 5'd1,  5'd1,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0,  5'd12, 5'd0,  1'b0);
    vecs[12] = mk(1'b1, 5'd0,  5'd0,  5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd13, 5'd0,  5'd12, 1'b1);
    vecs[13] = mk(1'b1, 5'd1,  5'd2,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0,  5'd13, 5'd0,  1'b1);
    vecs[14] = mk(1'b1, 5'd0,  5'd0,  5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd14, 5'd0,  5'd13, 1'b1);
    vecs[15] = mk(1'b1, 5'd14, 5'd0,  5'd9,  1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'd0,  5'd14, 5'd0,  1'b1);
    vecs[16] = mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0,  5'd0,  5'd14, 1'b1);
    vecs[17] = mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0,  5'd0,  5'd0,  1'b0);
    vecs[18] = mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0,  5'd0,  5'd0,  1'b0);
    vecs[19] = mk(1'b1, 5'd0,  5'd0,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd4,  5'd0,  5'd0,  1'b0);
    vecs[20] = mk(1'b0, 5'd4,  5'd4,  5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd15, 5'd4,  5'd0,  1'b0);
    vecs[21] = mk(1'b1, 5'd0,  5'd0,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd9,  5'd15, 5'd4,  1'b1);
    vecs[22] = mk(1'b1, 5'd9,  5'd0,  5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 5'd0,  5'd9,  5'd15, 1'b0);
    vecs[23] = mk(1'b1, 5'd9,  5'd9,  5'd17, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 5'd17, 5'd0,  5'd9,  1'b1);
    vecs[24] = mk(1'b1, 5'd0,  5'd0,  5'd20, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd20, 5'd17, 5'd0,  1'b0);
    vecs[25] = mk(1'b1, 5'd1,  5'd20, 5'd21, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 5'd0,  5'd20, 5'd17, 1'b1);
    vecs[26] = mk(1'b1, 5'd1,  5'd20, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 5'd21, 5'd0,  5'd20, 1'b1);
    vecs[27] = mk(1'b1, 5'd0,  5'd0,  5'd22, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5'd22, 5'd21, 5'd0,  1'b0);
    vecs[28] = mk(1'b0, 5'd22, 5'd22, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0,  5'd22, 5'd21, 1'b1);

    // Reset state, with an ID instruction present that must not cause a stall.
    rst = 1'b1;
    drive(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_stall", -1, 32'(stall), 32'd0);
    chk_regs(-1, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    rst = 1'b0;

    // Main table: stall is checked before the edge, registered outputs after it.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].dest,
            vecs[i].rw, vecs[i].mr, vecs[i].fl);
      #1;
      chk("stall", i, 32'(stall), 32'(vecs[i].st));
      @(posedge clk);
      #1;
      chk_regs(i, vecs[i].fa, vecs[i].fb, vecs[i].exd, vecs[i].memd,
               vecs[i].wbd, vecs[i].wbrw);
      @(negedge clk);
    end

    // Asynchronous reset with three writers in flight (last one a load).
    drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("pre_rst_stall", 100, 32'(stall), 32'd1);
    chk("pre_rst_wbrw", 100, 32'(wb_regwrite), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_stall", 101, 32'(stall), 32'd0);
    chk_regs(101, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    rst = 1'b0;

    // First edge after release is a normal advance.
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_regs(102, 2'b00, 2'b00, 5'd7, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_regs(103, 2'b00, 2'b00, 5'd0, 5'd7, 5'd0, 1'b0);
    @(posedge clk); #1;
    chk_regs(104, 2'b00, 2'b00, 5'd0, 5'd0, 5'd7, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
